// File: rtl/bp_be_cache_req_arbiter_pkg.sv
// Shared types and constants for the backend cache request arbiter.
package bp_be_cache_req_arbiter_pkg;

  typedef enum logic [1:0] {
    e_arb_idle,
    e_arb_meta,
    e_arb_wait
  } bp_be_cache_arb_state_e;

  localparam int unsigned bp_be_cache_arb_watchdog_width_gp = 16;
  localparam logic [15:0] bp_be_cache_arb_watchdog_max_gp   = 16'hFFFF;

  // Owner index width; never below one bit.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_be_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping. The caller owns the pointer so it only advances on handshake.
module bp_be_rr_picker
  import bp_be_cache_req_arbiter_pkg::*;
#(
  parameter  int unsigned num_req_p     = 2,
  localparam int unsigned lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]     req_v_i,
  input  logic [lg_num_req_lp-1:0] ptr_i,
  output logic [num_req_p-1:0]     grant_o,
  output logic [lg_num_req_lp-1:0] idx_o
);

  int unsigned               k;
  logic [lg_num_req_lp-1:0]  kidx;
  logic                      found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    kidx    = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      k    = (32'(ptr_i) + i) % num_req_p;
      kidx = lg_num_req_lp'(k);
      if (!found && req_v_i[kidx]) begin
        found         = 1'b1;
        grant_o[kidx] = 1'b1;
        idx_o         = kidx;
      end
    end
  end

endmodule

// File: rtl/bp_be_cache_req_arbiter.sv
// Round-robin sharing of one D$ miss/uncached request channel toward the LCE.
// Optional watchdog: define BP_BE_CACHE_ARB_WATCHDOG_EN.
module bp_be_cache_req_arbiter
  import bp_be_cache_req_arbiter_pkg::*;
#(
  parameter  int unsigned num_req_p     = 2,
  parameter  int unsigned req_width_p   = 128,
  parameter  int unsigned meta_width_p  = 16,
  localparam int unsigned lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,

  input  logic [num_req_p*req_width_p-1:0]  req_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p*meta_width_p-1:0] meta_i,
  input  logic [num_req_p-1:0]              meta_v_i,
  output logic [num_req_p-1:0]              critical_o,
  output logic [num_req_p-1:0]              complete_o,

  output logic [req_width_p-1:0]            cache_req_o,
  output logic                              cache_req_v_o,
  input  logic                              cache_req_ready_i,
  output logic [meta_width_p-1:0]           cache_req_metadata_o,
  output logic                              cache_req_metadata_v_o,
  input  logic                              cache_req_critical_i,
  input  logic                              cache_req_complete_i,

  output logic                              busy_o,
  output logic [lg_num_req_lp-1:0]          owner_o,
  output logic                              timeout_o
);

  bp_be_cache_arb_state_e    state_r;
  logic [lg_num_req_lp-1:0]  owner_r, rr_ptr_r, win_idx, rr_next;
  logic [num_req_p-1:0]      win_grant, owner_oh;
  logic [req_width_p-1:0]    req_arr  [num_req_p];
  logic [meta_width_p-1:0]   meta_arr [num_req_p];
  logic                      in_idle, in_meta, in_wait, handshake;

  for (genvar g = 0; g < num_req_p; g++) begin : g_slice
    assign req_arr[g]  = req_i[g*req_width_p +: req_width_p];
    assign meta_arr[g] = meta_i[g*meta_width_p +: meta_width_p];
  end

  bp_be_rr_picker #(.num_req_p(num_req_p)) picker (
    .req_v_i (req_v_i),
    .ptr_i   (rr_ptr_r),
    .grant_o (win_grant),
    .idx_o   (win_idx)
  );

  // Everything user-visible is squashed while reset is held.
  assign in_idle   = reset_n_i && (state_r == e_arb_idle);
  assign in_meta   = reset_n_i && (state_r == e_arb_meta);
  assign in_wait   = reset_n_i && (state_r == e_arb_wait);
  assign handshake = cache_req_v_o && cache_req_ready_i;
  assign rr_next   = (win_idx == lg_num_req_lp'(num_req_p - 1)) ? '0
                                                                 : win_idx + lg_num_req_lp'(1);

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_r] = 1'b1;
  end

  assign cache_req_v_o          = in_idle && (|req_v_i);
  assign cache_req_o            = req_arr[win_idx];
  assign req_ready_o            = in_idle ? (win_grant & {num_req_p{cache_req_ready_i}}) : '0;
  assign cache_req_metadata_v_o = in_meta && meta_v_i[owner_r];
  assign cache_req_metadata_o   = meta_arr[owner_r];
  assign critical_o             = ((in_meta || in_wait) && cache_req_critical_i) ? owner_oh : '0;
  assign complete_o             = ((in_meta || in_wait) && cache_req_complete_i) ? owner_oh : '0;
  assign busy_o                 = (state_r != e_arb_idle);
  assign owner_o                = owner_r;

  // Transaction FSM; pointer and owner move only on the request handshake.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r  <= e_arb_idle;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      unique case (state_r)
        e_arb_idle: if (handshake) begin
          owner_r  <= win_idx;
          rr_ptr_r <= rr_next;
          state_r  <= e_arb_meta;
        end
        e_arb_meta: begin
          if (cache_req_complete_i)      state_r <= e_arb_idle;
          else if (meta_v_i[owner_r])    state_r <= e_arb_wait;
        end
        e_arb_wait: if (cache_req_complete_i) state_r <= e_arb_idle;
        default: state_r <= e_arb_idle;
      endcase
    end
  end

`ifdef BP_BE_CACHE_ARB_WATCHDOG_EN
  logic [bp_be_cache_arb_watchdog_width_gp-1:0] wd_cnt_r;
  logic                                         timeout_r;

  // Saturating transaction age; timeout is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (handshake)
        wd_cnt_r <= '0;
      else if ((state_r != e_arb_idle) && (wd_cnt_r != bp_be_cache_arb_watchdog_max_gp))
        wd_cnt_r <= wd_cnt_r + 16'd1;
      if (wd_cnt_r == bp_be_cache_arb_watchdog_max_gp)
        timeout_r <= 1'b1;
    end
  end

  assign timeout_o = timeout_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !timeout_r && (wd_cnt_r == bp_be_cache_arb_watchdog_max_gp))
      $error("bp_be_cache_req_arbiter: watchdog timeout, owner %0d", owner_r);
  end
`endif
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Directed bench for bp_be_cache_req_arbiter; owners of granted requests are
// queued at grant time and matched against complete_o when it strobes.
module tb_bp_be_cache_req_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned RW = 16;
  localparam int unsigned MW = 8;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [N*RW-1:0] req_i;
  logic [N-1:0]    req_v_i, req_ready_o;
  logic [N*MW-1:0] meta_i;
  logic [N-1:0]    meta_v_i, critical_o, complete_o;
  logic [RW-1:0]   cache_req_o;
  logic            cache_req_v_o, cache_req_ready_i;
  logic [MW-1:0]   cache_req_metadata_o;
  logic            cache_req_metadata_v_o;
  logic            cache_req_critical_i, cache_req_complete_i;
  logic            busy_o, timeout_o;
  logic [0:0]      owner_o;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int ptr;
  int exp_own;

  always #5 clk_i = ~clk_i;

  bp_be_cache_req_arbiter #(.num_req_p(N), .req_width_p(RW), .meta_width_p(MW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_i(req_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .meta_i(meta_i), .meta_v_i(meta_v_i),
    .critical_o(critical_o), .complete_o(complete_o),
    .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_ready_i(cache_req_ready_i),
    .cache_req_metadata_o(cache_req_metadata_o),
    .cache_req_metadata_v_o(cache_req_metadata_v_o),
    .cache_req_critical_i(cache_req_critical_i),
    .cache_req_complete_i(cache_req_complete_i),
    .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference round-robin choice from the bench's own pointer.
  function automatic int rr_win(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      int k = (p + i) % N;
      if (v[k]) return k;
    end
    return 0;
  endfunction

  task automatic grant_expect(input string tag);
    exp_own = rr_win(req_v_i, ptr);
    chk(tag, 32'(req_ready_o), 32'(1 << exp_own));
    sb.push_back(exp_own);
    ptr = (exp_own + 1) % N;
  endtask

  task automatic sb_complete(input string tag);
    int e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed complete %0b expected no transaction", tag, complete_o);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(complete_o), 32'(1 << e));
    end
  endtask

  initial begin
    reset_n_i = 1'b0; req_i = {16'h5A5A, 16'hA5A5}; req_v_i = '0;
    meta_i = {8'hC3, 8'h3C}; meta_v_i = '0; cache_req_ready_i = 1'b0;
    cache_req_critical_i = 1'b0; cache_req_complete_i = 1'b0; ptr = 0;

    // Reset: outputs quiet even with activity on the inputs.
    tick();
    req_v_i = 2'b11; cache_req_ready_i = 1'b1;
    cache_req_complete_i = 1'b1; cache_req_critical_i = 1'b1; #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_owner", 32'(owner_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_req_v", 32'(cache_req_v_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_complete", 32'(complete_o), 0);
    chk("rst_critical", 32'(critical_o), 0);
    tick();
    reset_n_i = 1'b1; req_v_i = '0; cache_req_complete_i = 1'b0; cache_req_critical_i = 1'b0;

    // Single requester: grant, meta, critical at +3, complete at +5.
    req_v_i = 2'b01; #1;
    chk("s_req_v", 32'(cache_req_v_o), 1);
    chk("s_req", 32'(cache_req_o), 32'h0000A5A5);
    grant_expect("s_ready");
    tick();
    req_v_i = '0; meta_v_i = 2'b01; #1;
    chk("s_meta_v", 32'(cache_req_metadata_v_o), 1);
    chk("s_meta", 32'(cache_req_metadata_o), 32'h3C);
    chk("s_req_v_meta", 32'(cache_req_v_o), 0);
    chk("s_busy", 32'(busy_o), 1);
    tick(); meta_v_i = '0;
    tick(); tick();
    cache_req_critical_i = 1'b1; #1;
    chk("s_critical", 32'(critical_o), 2'b01);
    tick(); cache_req_critical_i = 1'b0;
    tick(); cache_req_complete_i = 1'b1; #1;
    sb_complete("s_complete");
    chk("s_busy_at_complete", 32'(busy_o), 1);
    tick(); cache_req_complete_i = 1'b0; #1;
    chk("s_busy_after", 32'(busy_o), 0);

    // Contention: both valid for four transactions.
    req_v_i = 2'b11; meta_v_i = '0;
    for (int t = 0; t < 4; t++) begin
      #1;
      grant_expect("c_ready");
      tick();
      chk("c_owner", 32'(owner_o), 32'(exp_own));
      meta_v_i = 2'b11; #1;
      chk("c_req_v_meta", 32'(cache_req_v_o), 0);
      chk("c_meta", 32'(cache_req_metadata_o), (exp_own == 1) ? 32'hC3 : 32'h3C);
      tick();
      meta_v_i = '0; cache_req_complete_i = 1'b1; #1;
      sb_complete("c_complete");
      tick();
      cache_req_complete_i = 1'b0;
    end

    // Backpressure: requester 1 waits on LCE ready for three cycles.
    req_v_i = 2'b10; cache_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(req_ready_o), 0);
      chk("bp_busy", 32'(busy_o), 0);
      chk("bp_req_v", 32'(cache_req_v_o), 1);
      tick();
    end
    cache_req_ready_i = 1'b1; #1;
    grant_expect("bp_grant");
    tick();
    chk("bp_owner", 32'(owner_o), 1);

    // Early complete in META drops the metadata.
    req_v_i = '0; cache_req_complete_i = 1'b1; #1;
    chk("ec_meta_v", 32'(cache_req_metadata_v_o), 0);
    sb_complete("ec_complete");
    tick();
    cache_req_complete_i = 1'b0; meta_v_i = 2'b10; #1;
    chk("ec_late_meta", 32'(cache_req_metadata_v_o), 0);
    chk("ec_idle", 32'(busy_o), 0);
    tick(); meta_v_i = '0;

    // Isolation: owner 1 ignores requester 0 metadata.
    req_v_i = 2'b10; #1;
    grant_expect("iso_grant");
    tick();
    req_v_i = '0; meta_v_i = 2'b01; cache_req_complete_i = 1'b1; #1;
    chk("iso_meta_v", 32'(cache_req_metadata_v_o), 0);
    sb_complete("iso_complete");
    tick(); meta_v_i = '0; cache_req_complete_i = 1'b0;

    // Metadata and complete together in META.
    req_v_i = 2'b01; #1;
    grant_expect("mc_grant");
    tick();
    req_v_i = '0; meta_v_i = 2'b01; cache_req_complete_i = 1'b1; #1;
    chk("mc_meta_v", 32'(cache_req_metadata_v_o), 1);
    sb_complete("mc_complete");
    tick(); meta_v_i = '0; cache_req_complete_i = 1'b0; #1;
    chk("mc_idle", 32'(busy_o), 0);

    // Critical and complete together in WAIT.
    req_v_i = 2'b11; #1;
    grant_expect("cc_grant");
    tick();
    req_v_i = '0; meta_v_i = 2'b10;
    tick();
    meta_v_i = '0; cache_req_critical_i = 1'b1; cache_req_complete_i = 1'b1; #1;
    chk("cc_critical", 32'(critical_o), 2'b10);
    sb_complete("cc_complete");
    tick(); cache_req_critical_i = 1'b0; cache_req_complete_i = 1'b0;

    // Reset in WAIT abandons the transaction and rewinds the pointer.
    req_v_i = 2'b11; #1;
    exp_own = rr_win(req_v_i, ptr);
    chk("rw_ready", 32'(req_ready_o), 32'(1 << exp_own));
    tick();
    req_v_i = '0; meta_v_i = 2'b01;
    tick();
    meta_v_i = '0; #1;
    chk("rw_busy", 32'(busy_o), 1);
    reset_n_i = 1'b0; cache_req_complete_i = 1'b1; #1;
    chk("rw_complete_in_rst", 32'(complete_o), 0);
    tick();
    reset_n_i = 1'b1; #1;
    ptr = 0;
    chk("rw_complete_after", 32'(complete_o), 0);
    chk("rw_owner", 32'(owner_o), 0);
    chk("rw_busy_after", 32'(busy_o), 0);
    tick(); cache_req_complete_i = 1'b0;
    req_v_i = 2'b11; #1;
    chk("rw_ptr_reset", 32'(req_ready_o), 32'(1 << rr_win(req_v_i, ptr)));

`ifdef BP_BE_CACHE_ARB_WATCHDOG_EN
    // Stall in WAIT long enough to saturate the watchdog.
    grant_expect("wd_grant");
    tick();
    req_v_i = '0; meta_v_i = 2'b01;
    tick();
    meta_v_i = '0;
    for (int i = 0; i < 65540; i++) @(posedge clk_i);
    #1;
    chk("wd_timeout", 32'(timeout_o), 1);
    cache_req_complete_i = 1'b1; #1;
    sb_complete("wd_complete");
    tick(); cache_req_complete_i = 1'b0; #1;
    chk("wd_sticky", 32'(timeout_o), 1);
`else
    req_v_i = '0;
    chk("no_timeout", 32'(timeout_o), 0);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
